// File: rtl/float_acc_seq.sv
// rtl/float_acc_seq.sv - start/done initiator that folds an operand stream through an external float adder
// Holds the running sum, sticky adder status and operand count until the consumer takes the total.
module float_acc_seq #(
   parameter int FLOAT_WIDTH = 32,
   parameter int COUNT_WIDTH = 8,
   parameter int TIMEOUT     = 64
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_in_valid,
   output logic                   o_in_ready,
   input  logic [FLOAT_WIDTH-1:0] i_in_data,
   input  logic                   i_in_last,
   output logic                   o_add_start,
   output logic                   o_add_sub,
   output logic [FLOAT_WIDTH-1:0] o_add_a,
   output logic [FLOAT_WIDTH-1:0] o_add_b,
   input  logic [FLOAT_WIDTH-1:0] i_add_o,
   input  logic                   i_add_nan,
   input  logic                   i_add_overflow,
   input  logic                   i_add_underflow,
   input  logic                   i_add_zero,
   input  logic                   i_add_done,
   output logic                   o_out_valid,
   input  logic                   i_out_ready,
   output logic [FLOAT_WIDTH-1:0] o_out_data,
   output logic [4:0]             o_out_flags,
   output logic [COUNT_WIDTH-1:0] o_out_count
);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [FLOAT_WIDTH-1:0] r_acc;
   logic [FLOAT_WIDTH-1:0] r_add_a;
   logic [FLOAT_WIDTH-1:0] r_add_b;
   logic                   r_last_q;
   logic                   r_done_q;
   logic [TW-1:0]          r_wait_cnt;
   logic [4:0]             r_flags;
   logic [COUNT_WIDTH-1:0] r_count;

   logic                   w_done_edge;
   logic                   w_accept;
   logic                   w_complete;
   logic                   w_timeout;
   logic                   w_release;

   // A done level still high from the previous add must not complete the new one.
   assign w_done_edge = i_add_done & ~r_done_q;

   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_complete = 1'b0;
      w_timeout  = 1'b0;
      w_release  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_in_valid) begin
               w_accept = 1'b1;
               w_next   = S_ISSUE;
            end
         end
         S_ISSUE: w_next = S_WAIT;
         S_WAIT: begin
            if (w_done_edge) begin
               w_complete = 1'b1;
               w_next     = r_last_q ? S_OUTPUT : S_IDLE;
            end else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
               w_timeout = 1'b1;
               w_next    = S_OUTPUT;
            end
         end
         S_OUTPUT: begin
            if (i_out_ready) begin
               w_release = 1'b1;
               w_next    = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_acc      <= '0;
         r_add_a    <= '0;
         r_add_b    <= '0;
         r_last_q   <= 1'b0;
         r_done_q   <= 1'b0;
         r_wait_cnt <= '0;
         r_flags    <= '0;
         r_count    <= '0;
      end else begin
         r_state  <= w_next;
         r_done_q <= i_add_done;
         if (w_accept) begin
            r_add_a  <= r_acc;
            r_add_b  <= i_in_data;
            r_last_q <= i_in_last;
         end
         if (r_state == S_ISSUE) begin
            r_wait_cnt <= '0;
         end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
         end
         if (w_complete) begin
            r_acc      <= i_add_o;
            r_flags[3] <= r_flags[3] | i_add_nan;
            r_flags[2] <= r_flags[2] | i_add_overflow;
            r_flags[1] <= r_flags[1] | i_add_underflow;
            r_flags[0] <= i_add_zero;
            if (r_count != '1) begin
               r_count <= r_count + COUNT_WIDTH'(1);
            end
         end
         if (w_timeout) begin
            r_flags[4] <= 1'b1;
         end
         if (w_release) begin
            r_acc   <= '0;
            r_flags <= '0;
            r_count <= '0;
         end
      end
   end

   assign o_in_ready  = (r_state == S_IDLE);
   assign o_add_start = (r_state == S_ISSUE);
   assign o_add_sub   = 1'b0;
   assign o_add_a     = r_add_a;
   assign o_add_b     = r_add_b;
   assign o_out_valid = (r_state == S_OUTPUT);
   assign o_out_data  = r_acc;
   assign o_out_flags = r_flags;
   assign o_out_count = r_count;

endmodule

// File: tb/tb_float_acc_seq.sv
// tb/tb_float_acc_seq.sv - randomized self-checking bench for float_acc_seq
// A behavioural adder stand-in answers start pulses; expected sums are a fold over the operand list.
module tb_float_acc_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_last;
   logic [31:0] in_data;
   logic        add_start, add_sub;
   logic [31:0] add_a, add_b, add_o;
   logic        add_nan, add_overflow, add_underflow, add_zero, add_done;
   logic        out_valid, out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_flags;
   logic [7:0]  out_count;

   int n_chk = 0;
   int n_err = 0;
   int n_starts = 0;

   always #5 clk = ~clk;

   float_acc_seq #(.FLOAT_WIDTH(32), .COUNT_WIDTH(8), .TIMEOUT(64)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data), .i_in_last(in_last),
      .o_add_start(add_start), .o_add_sub(add_sub), .o_add_a(add_a), .o_add_b(add_b),
      .i_add_o(add_o), .i_add_nan(add_nan), .i_add_overflow(add_overflow),
      .i_add_underflow(add_underflow), .i_add_zero(add_zero), .i_add_done(add_done),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
      .o_out_flags(out_flags), .o_out_count(out_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_nan(input logic [31:0] r);
      return (r[30:23] == 8'hff) && (r[22:0] != 0);
   endfunction
   function automatic bit is_inf(input logic [31:0] r);
      return r[30:0] == 31'h7f800000;
   endfunction
   function automatic bit is_den(input logic [31:0] r);
      return (r[30:23] == 8'h00) && (r[22:0] != 0);
   endfunction
   function automatic bit is_zero(input logic [31:0] r);
      return r[30:0] == 31'h0;
   endfunction

   // Stand-in adder: exact for the identities and table entries, deterministic scramble otherwise.
   function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
      if (is_zero(a)) return b;
      if (is_zero(b)) return a;
      if (a == 32'h3f800000 && b == 32'h40000000) return 32'h40400000;
      if (a == 32'h40400000 && b == 32'h40400000) return 32'h40c00000;
      if (is_nan(a)) return a;
      if (is_nan(b)) return b;
      return (a ^ {b[15:0], b[31:16]}) + 32'h9e3779b9;
   endfunction

   logic [31:0] m_o, m_pend;
   logic        m_done, m_late, m_busy;
   int          m_cnt;
   bit          m_hang = 1'b0;
   int          m_lat = 2;

   assign add_o         = m_o;
   assign add_done      = m_done | m_late;
   assign add_nan       = is_nan(m_o);
   assign add_overflow  = is_inf(m_o);
   assign add_underflow = is_den(m_o);
   assign add_zero      = is_zero(m_o);

   always @(posedge clk) begin
      if (rst) begin
         m_done <= 1'b0;
         m_busy <= 1'b0;
         m_o    <= '0;
         m_cnt  <= 0;
      end else if (add_start) begin
         m_done <= 1'b0;
         m_busy <= !m_hang;
         m_cnt  <= m_lat;
         m_pend <= f_add(add_a, add_b);
      end else if (m_busy) begin
         if (m_cnt <= 1) begin
            m_done <= 1'b1;
            m_o    <= m_pend;
            m_busy <= 1'b0;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   logic [63:0] exp_issue[$];
   logic [63:0] mon_e;
   logic [31:0] mon_a, mon_b;
   bit          mon_track = 1'b0;
   bit          prev_start = 1'b0;

   always @(negedge clk) begin
      if (!rst && add_start) begin
         n_starts++;
         if (exp_issue.size() == 0) begin
            check("issue_unexpected", 1, 0);
         end else begin
            mon_e = exp_issue.pop_front();
            check("issue_a", add_a, mon_e[63:32]);
            check("issue_b", add_b, mon_e[31:0]);
         end
         check("issue_in_ready", in_ready, 0);
         check("start_single_cycle", prev_start, 0);
         check("add_sub", add_sub, 0);
      end else if (!rst && mon_track && !in_ready && !out_valid) begin
         check("hold_a", add_a, mon_a);
         check("hold_b", add_b, mon_b);
      end
      if (add_start) begin
         mon_track = 1'b1;
         mon_a     = add_a;
         mon_b     = add_b;
      end else if (in_ready || out_valid) begin
         mon_track = 1'b0;
      end
      prev_start = add_start;
   end

   task automatic send_op(input logic [31:0] x, input bit last, input logic [31:0] exp_a);
      int t = 0;
      exp_issue.push_back({exp_a, x});
      while (!in_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", in_ready, 1);
         return;
      end
      in_valid = 1'b1;
      in_data  = x;
      in_last  = last;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic get_out(input logic [31:0] ed, input logic [4:0] ef, input logic [7:0] ec,
                          input int hold, input string tag);
      int t = 0;
      while (!out_valid && t < 500) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_valid"}, out_valid, 1);
      if (!out_valid) return;
      check({tag, "_data"}, out_data, ed);
      check({tag, "_flags"}, out_flags, ef);
      check({tag, "_count"}, out_count, ec);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, out_valid, 1);
         check({tag, "_hold_data"}, out_data, ed);
         check({tag, "_hold_flags"}, out_flags, ef);
         check({tag, "_hold_count"}, out_count, ec);
         check({tag, "_hold_in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_released"}, out_valid, 0);
      check({tag, "_in_ready_after"}, in_ready, 1);
      check({tag, "_cleared"}, {out_data, out_flags, out_count} == 45'd0, 1);
   endtask

   task automatic run_sum(input logic [31:0] ops[$], input int hold, input string tag);
      logic [31:0] acc = 32'h0;
      logic [4:0]  fl = 5'b0;
      logic [7:0]  cnt = 8'd0;
      for (int i = 0; i < ops.size(); i++) begin
         send_op(ops[i], i == ops.size() - 1, acc);
         acc   = f_add(acc, ops[i]);
         fl[3] = fl[3] | is_nan(acc);
         fl[2] = fl[2] | is_inf(acc);
         fl[1] = fl[1] | is_den(acc);
         fl[0] = is_zero(acc);
         if (cnt != 8'hff) cnt++;
      end
      get_out(acc, fl, cnt, hold, tag);
   endtask

   task automatic single_op(input string tag);
      int s0 = n_starts;
      int t = 0;
      m_lat = 2;
      send_op(32'h40a00000, 1'b1, 32'h0);
      check({tag, "_start"}, add_start, 1);
      while (!out_valid && t < 500) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_latency"}, t, 4);
      get_out(32'h40a00000, 5'b0, 8'd1, 0, tag);
      check({tag, "_starts"}, n_starts - s0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   logic [31:0] pool [8] = '{32'h3f800000, 32'h40000000, 32'h7fc00000, 32'h7f800000,
                            32'h00000001, 32'h80000000, 32'h00000000, 32'hc0400000};

   initial begin
      logic [31:0] ops[$];
      int s0, t;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0; m_late = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_flags", out_flags, 0);
      check("rst_out_count", out_count, 0);
      check("rst_add_a", add_a, 0);
      check("rst_add_b", add_b, 0);
      check("rst_add_start", add_start, 0);
      rst = 1'b0;
      @(negedge clk);

      single_op("single");

      s0 = n_starts; m_lat = 3;
      ops = '{32'h3f800000, 32'h40000000, 32'h40400000};
      run_sum(ops, 0, "stream3");
      check("stream3_starts", n_starts - s0, 3);

      m_lat = 1;
      ops = '{32'h3f800000, 32'h40000000};
      run_sum(ops, 5, "backpressure");

      ops = '{32'h7fc00000, 32'h3f800000};
      run_sum(ops, 0, "nan_sticky");

      m_hang = 1'b1;
      send_op(32'h3f800000, 1'b1, 32'h0);
      t = 0;
      while (!out_valid && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("timeout_gap", t, 65);
      get_out(32'h0, 5'b10000, 8'd0, 2, "timeout");
      m_hang = 1'b0;

      m_hang = 1'b1;
      send_op(32'h3f800000, 1'b1, 32'h0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_hang = 1'b0;
      m_late = 1'b1;
      @(negedge clk);
      m_late = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("late_done_out_valid", out_valid, 0);
         check("late_done_in_ready", in_ready, 1);
         check("late_done_acc", out_data, 0);
         @(negedge clk);
      end
      single_op("after_reset");

      for (int s = 0; s < 25; s++) begin
         int n;
         ops = {};
         n = $urandom_range(1, 6);
         m_lat = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 0) ops.push_back(pool[$urandom_range(0, 7)]);
            else ops.push_back($urandom);
         end
         run_sum(ops, $urandom_range(0, 3), "random");
      end

      m_lat = 1;
      ops = {};
      for (int i = 0; i < 260; i++) ops.push_back($urandom);
      run_sum(ops, 0, "saturate");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
